msx_slot_bus_master: RTL
========================

Name: msx_slot_bus_master

Overview:
- Host-side initiator for the MSX cartridge slot bus: turns a simple req/ack command port into Z80-style memory read/write cycles (T1/T2/Tw/T3) toward the cartridge's mapper/SCC decoder.
- All cycle timing advances only on phiM positive-edge clock enables, so the cartridge's synchronizers see legal bus timing.
- Used for the on-FPGA self-test harness and as the stimulus engine for cartridge-level verification.

Parameters:
- FORCED_WAITS, 0, number of Tw states always inserted after T2 (0..7).
- WAIT_TIMEOUT, 255, maximum consecutive Tw ticks caused by i_wait_n low before the cycle is aborted (1..255).

Ports:
- emuclk  in  1  emulator master clock
- rst_n  in  1  reset
- i_mclk_pcen_n  in  1  phiM positive-edge clock enable, active low; one "tick" = one emuclk with this low
- i_req  in  1  command request, sampled every emuclk
- i_req_we  in  1  1 = write cycle, 0 = read cycle
- i_req_addr  in  16  cycle address
- i_req_wdata  in  8  write data
- o_busy  out  1  cycle in progress
- o_ack  out  1  one-emuclk pulse at cycle completion
- o_timeout  out  1  one-emuclk pulse, coincident with o_ack, when the cycle was aborted
- o_rdata  out  8  read data, valid from o_ack until the next accepted request
- o_addr  out  16  slot address bus
- o_sltsl_n  out  1  slot select
- o_mreq_n  out  1  memory request
- o_rd_n  out  1  read strobe
- o_wr_n  out  1  write strobe
- o_dout  out  8  data driven to the cartridge
- o_dout_oe  out  1  data bus drive enable
- i_din  in  8  data from the cartridge
- i_wait_n  in  1  wait request from the cartridge, active low

Behaviour:
- Reset and clock: rst_n is synchronous and active-low; the block is clocked by emuclk.
- Reset values: o_busy=0, o_ack=0, o_timeout=0, o_rdata=8'h00, o_addr=16'h0000, o_sltsl_n=1, o_mreq_n=1, o_rd_n=1, o_wr_n=1, o_dout=8'h00, o_dout_oe=0. State is IDLE and all counters are 0.
- Reset mid-cycle: strobes return high at the next emuclk edge. No ack and no timeout are issued.
- Accept: in IDLE with i_req=1, latch we, addr and wdata on that emuclk. o_busy rises on the next edge and the state becomes T1.
  - i_req while busy is ignored and not queued.
  - A request is accepted in the same emuclk as o_ack only if the state is already IDLE, so there are no back-to-back accepts without one IDLE emuclk.
- State transitions occur only on ticks. Each of T1, T2, Tw and T3 lasts exactly one tick.
- T1: o_addr = latched address; all strobes high. For a write, o_dout = wdata and o_dout_oe=1.
- T2: o_sltsl_n=0 and o_mreq_n=0. o_rd_n=0 for a read; o_wr_n=0 for a write.
- At the end of T2, the next state is Tw if FORCED_WAITS>0 or i_wait_n=0; otherwise T3.
- Tw:
  - Strobes are held.
  - The forced-wait count is consumed first.
  - After that, stay in Tw while i_wait_n=0, incrementing the wait counter.
  - If the counter reaches WAIT_TIMEOUT while i_wait_n is still 0, go to T3 with the abort flag set.
- T3:
  - Strobes are held for the whole tick.
  - On the tick that leaves T3:
    - for a read, capture o_rdata <= i_din;
    - deassert all strobes and o_dout_oe;
    - o_busy <= 0;
    - o_ack <= 1 for one emuclk; o_timeout <= abort.
  - o_addr holds its last value.
  - On an aborted read, o_rdata = 8'hFF.
- Fixed cycle length, in ticks from the first T1 tick to the ack: 3 + FORCED_WAITS + extra waits.
- i_wait_n is sampled only on ticks, at the end of T2 and of each non-forced Tw.
- Counter widths: forced-wait counter 3 bits; wait counter 8 bits, saturating at WAIT_TIMEOUT.

Decomposition:
- Shared package msx_bus_pkg holds:
  - the state enum (IDLE, T1, T2, TW, T3);
  - the cartridge register address constants: 5000h, 7000h, 9000h, B000h, 4FFBh–4FFFh, 9800h SCC window;
  - the default WAIT_TIMEOUT.
- No sub-module; a single FSM with two counters.

Test Plan:
- Write 8'h3F to 9000h, FORCED_WAITS=0, i_wait_n=1 → o_wr_n low for exactly 2 ticks (T2, T3), o_addr=9000h from T1 through T3, o_dout_oe high for 3 ticks, ack 3 ticks after accept.
- Read 9800h with i_din=8'hA5 → o_rd_n low for 2 ticks, o_rdata=8'hA5 at ack, o_timeout=0.
- Read with i_wait_n held low for 4 ticks from T2 → exactly 4 Tw ticks, ack at tick 7, data captured in T3.
- i_wait_n stuck low with WAIT_TIMEOUT=5 → 5 Tw ticks, then T3, ack and timeout pulse together, o_rdata=8'hFF.
- FORCED_WAITS=2, write 4FFBh=8'h01 → 2 Tw ticks regardless of i_wait_n, 5-tick cycle; a second i_req during the cycle is ignored (exactly one ack).
- rst_n asserted during T2 of a write → next emuclk: all strobes 1, o_dout_oe=0, o_busy=0, no ack; next request completes normally.

Source files
------------

// File: rtl/msx_slot_bus_master_pkg.sv
// Shared definitions for the MSX slot bus master.
//   bus_state_t          : bus cycle phase (IDLE, T1, T2, TW, T3)
//   ADDR_*               : cartridge mapper / SCC register addresses
//   DEFAULT_WAIT_TIMEOUT : default limit on cartridge-requested wait states
package msx_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    TW,
    T3
  } bus_state_t;

  // Mapper bank-select registers
  localparam logic [15:0] ADDR_BANK0      = 16'h5000;
  localparam logic [15:0] ADDR_BANK1      = 16'h7000;
  localparam logic [15:0] ADDR_BANK2      = 16'h9000;
  localparam logic [15:0] ADDR_BANK3      = 16'hB000;
  // Mapper configuration window 4FFBh..4FFFh
  localparam logic [15:0] ADDR_CFG_FIRST  = 16'h4FFB;
  localparam logic [15:0] ADDR_CFG_LAST   = 16'h4FFF;
  // SCC register window base
  localparam logic [15:0] ADDR_SCC_WINDOW = 16'h9800;

  localparam int unsigned DEFAULT_WAIT_TIMEOUT = 255;

endpackage

// File: rtl/msx_slot_bus_master_if.sv
// Command port and cartridge slot bus of the MSX slot bus master.
//   Command : i_req, i_req_we, i_req_addr, i_req_wdata -> o_busy, o_ack,
//             o_timeout, o_rdata
//   Slot bus: o_addr, o_sltsl_n, o_mreq_n, o_rd_n, o_wr_n, o_dout, o_dout_oe
//             <- i_din, i_wait_n
// modport master: the bus master itself; modport slave: host + cartridge side.
interface msx_slot_bus_master_if;
  logic        i_req;
  logic        i_req_we;
  logic [15:0] i_req_addr;
  logic [7:0]  i_req_wdata;
  logic        o_busy;
  logic        o_ack;
  logic        o_timeout;
  logic [7:0]  o_rdata;
  logic [15:0] o_addr;
  logic        o_sltsl_n;
  logic        o_mreq_n;
  logic        o_rd_n;
  logic        o_wr_n;
  logic [7:0]  o_dout;
  logic        o_dout_oe;
  logic [7:0]  i_din;
  logic        i_wait_n;

  modport master (
    input  i_req, i_req_we, i_req_addr, i_req_wdata, i_din, i_wait_n,
    output o_busy, o_ack, o_timeout, o_rdata, o_addr, o_sltsl_n, o_mreq_n,
           o_rd_n, o_wr_n, o_dout, o_dout_oe
  );

  modport slave (
    output i_req, i_req_we, i_req_addr, i_req_wdata, i_din, i_wait_n,
    input  o_busy, o_ack, o_timeout, o_rdata, o_addr, o_sltsl_n, o_mreq_n,
           o_rd_n, o_wr_n, o_dout, o_dout_oe
  );
endinterface

// File: rtl/msx_slot_bus_master.sv
// MSX cartridge slot bus master: turns a req/ack command into a Z80-style
// memory cycle T1/T2/[Tw...]/T3, advancing only on phiM ticks.
//   emuclk        : emulator master clock
//   rst_n         : synchronous active-low reset
//   i_mclk_pcen_n : phiM positive-edge enable, active low (one tick)
//   bus           : command port and slot bus (msx_slot_bus_master_if.master)
module msx_slot_bus_master
  import msx_bus_pkg::*;
#(
  parameter int unsigned FORCED_WAITS = 0,
  parameter int unsigned WAIT_TIMEOUT = DEFAULT_WAIT_TIMEOUT
) (
  input  logic                         emuclk,
  input  logic                         rst_n,
  input  logic                         i_mclk_pcen_n,
  msx_slot_bus_master_if.master        bus
);

  localparam logic [2:0] FW_N = 3'(FORCED_WAITS);
  localparam logic [7:0] WT_N = 8'(WAIT_TIMEOUT);

  bus_state_t state, state_d;
  logic [2:0] fw_cnt, fw_cnt_d;
  logic [7:0] wait_cnt, wait_cnt_d;
  logic       abort, abort_d;
  logic       wait_pend, wait_pend_d;
  logic       we_q;
  logic       tick;
  logic       accept;
  logic       strobe_on;
  logic       finish;

  assign tick = ~i_mclk_pcen_n;

  always_comb begin
    state_d     = state;
    fw_cnt_d    = fw_cnt;
    wait_cnt_d  = wait_cnt;
    abort_d     = abort;
    wait_pend_d = wait_pend;
    accept      = 1'b0;
    strobe_on   = 1'b0;
    finish      = 1'b0;
    unique case (state)
      IDLE: begin
        // Accept is not tick-gated; T1 then waits for the next tick.
        if (bus.i_req) begin
          accept      = 1'b1;
          state_d     = T1;
          fw_cnt_d    = '0;
          wait_cnt_d  = '0;
          abort_d     = 1'b0;
          wait_pend_d = 1'b0;
        end
      end
      T1: begin
        if (tick) begin
          strobe_on = 1'b1;
          state_d   = T2;
        end
      end
      T2: begin
        if (tick) begin
          wait_pend_d = ~bus.i_wait_n;
          state_d     = (FW_N != '0 || !bus.i_wait_n) ? TW : T3;
        end
      end
      TW: begin
        if (tick) begin
          if (fw_cnt != FW_N) begin
            // Forced waits do not sample i_wait_n; a wait seen at the end of
            // T2 keeps the cycle in Tw after the forced ones are used up.
            fw_cnt_d = fw_cnt + 3'd1;
            if (fw_cnt + 3'd1 == FW_N && !wait_pend) begin
              state_d = T3;
            end
          end else if (!bus.i_wait_n) begin
            wait_cnt_d = wait_cnt + 8'd1;
            if (wait_cnt_d == WT_N) begin
              abort_d = 1'b1;
              state_d = T3;
            end
          end else begin
            state_d = T3;
          end
        end
      end
      T3: begin
        if (tick) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge emuclk) begin
    if (!rst_n) begin
      state         <= IDLE;
      fw_cnt        <= '0;
      wait_cnt      <= '0;
      abort         <= 1'b0;
      wait_pend     <= 1'b0;
      we_q          <= 1'b0;
      bus.o_busy    <= 1'b0;
      bus.o_ack     <= 1'b0;
      bus.o_timeout <= 1'b0;
      bus.o_rdata   <= '0;
      bus.o_addr    <= '0;
      bus.o_sltsl_n <= 1'b1;
      bus.o_mreq_n  <= 1'b1;
      bus.o_rd_n    <= 1'b1;
      bus.o_wr_n    <= 1'b1;
      bus.o_dout    <= '0;
      bus.o_dout_oe <= 1'b0;
    end else begin
      state         <= state_d;
      fw_cnt        <= fw_cnt_d;
      wait_cnt      <= wait_cnt_d;
      abort         <= abort_d;
      wait_pend     <= wait_pend_d;
      bus.o_ack     <= finish;
      bus.o_timeout <= finish & abort;
      if (accept) begin
        we_q       <= bus.i_req_we;
        bus.o_busy <= 1'b1;
        bus.o_addr <= bus.i_req_addr;
        if (bus.i_req_we) begin
          bus.o_dout    <= bus.i_req_wdata;
          bus.o_dout_oe <= 1'b1;
        end
      end
      if (strobe_on) begin
        bus.o_sltsl_n <= 1'b0;
        bus.o_mreq_n  <= 1'b0;
        bus.o_rd_n    <= we_q;
        bus.o_wr_n    <= ~we_q;
      end
      if (finish) begin
        bus.o_sltsl_n <= 1'b1;
        bus.o_mreq_n  <= 1'b1;
        bus.o_rd_n    <= 1'b1;
        bus.o_wr_n    <= 1'b1;
        bus.o_dout_oe <= 1'b0;
        bus.o_busy    <= 1'b0;
        if (!we_q) begin
          bus.o_rdata <= abort ? 8'hFF : bus.i_din;
        end
      end
    end
  end

endmodule
